// File: rtl/aes128_iter_ctrl.sv
// aes128_iter_ctrl - iterative AES-128 encryptor sequencer.
//
// Takes one plaintext/key pair per valid/ready handshake. It applies AddRoundKey
// with the cipher key on accept, then runs one full round per clock for rounds
// 1..9. Round 10 is the final round without MixColumns. Each round key is
// derived on the fly from the previous one. The ciphertext is held on out_ct
// until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   plaintext/key offered
//   in_ready   block can accept (IDLE only)
//   in_pt      plaintext, bits[127:120] = byte0, state[r][c] = byte 4c+r
//   in_key     cipher key, same byte order
//   out_valid  ciphertext available
//   out_ready  consumer accepts ciphertext
//   out_ct     ciphertext, same byte order
//   busy       high while rounds are being applied
//   round      round being applied (0 idle, 1..10 run, 10 done)
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for a plaintext/key pair
// ST_RUN  | applying rounds 1..10, one per clock
// ST_DONE | ciphertext presented, waiting for out_ready

module aes128_iter_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         busy,
  output logic [3:0]   round
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes128_iter_ctrl supports only NUM_ROUNDS = 10");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fsm_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0 sits in the top byte of the table, so the index is 255-x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_t         r_fsm, w_fsm_nxt;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;

  logic         w_last;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [127:0] w_rkey;
  logic [7:0]   w_sb [16];
  logic [7:0]   w_sr [16];
  logic [7:0]   w_mc [16];
  logic [127:0] w_round_out;

  assign w_last = (r_round == 4'(NUM_ROUNDS));

  // Next round key from the current one.
  always_comb begin
    w_k0   = r_key[127:96] ^ subword({r_key[23:0], r_key[31:24]}) ^ {rcon(r_round), 24'h0};
    w_k1   = r_key[95:64] ^ w_k0;
    w_k2   = r_key[63:32] ^ w_k1;
    w_k3   = r_key[31:0]  ^ w_k2;
    w_rkey = {w_k0, w_k1, w_k2, w_k3};
  end

  // SubBytes -> ShiftRows -> MixColumns (skipped in the last round) -> AddRoundKey.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    w_round_out = '0;
    for (int i = 0; i < 16; i++) begin
      w_sb[i] = sbox(r_state[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = w_sr[4*c];
      a1 = w_sr[4*c+1];
      a2 = w_sr[4*c+2];
      a3 = w_sr[4*c+3];
      w_mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      w_mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      w_mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      w_mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int i = 0; i < 16; i++) begin
      w_round_out[127-8*i -: 8] = (w_last ? w_sr[i] : w_mc[i]) ^ w_rkey[127-8*i -: 8];
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_key   <= '0;
      r_round <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= in_pt ^ in_key;
            r_key   <= in_key;
            r_round <= 4'd1;
          end
        end
        ST_RUN: begin
          r_state <= w_round_out;
          if (!w_last) begin
            r_key   <= w_rkey;
            r_round <= r_round + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_round <= '0;
        end
        default: r_round <= '0;
      endcase
    end
  end

  assign out_ct = r_state;
  assign round  = r_round;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
module tb_aes128_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_pt = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_ct;
  logic         busy;
  logic [3:0]   round;

  aes128_iter_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
    .busy(busy), .round(round)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K1_B  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  int           acc_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Record the edge at which every accepted block enters.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc + 1);
  end

  // Scoreboard monitor.
  logic         prev_ov = 1'b0;
  logic [127:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected no output", out_ct);
        end else begin
          chk("ct", out_ct, exp_q[0]);
          chk("latency", 128'(cyc - acc_q[0]), 128'd10);
          chk("done_flags", 128'({in_ready, busy, round}), 128'({1'b0, 1'b0, 4'd10}));
        end
        held = out_ct;
      end else if (out_valid) begin
        chk("ct_stable", out_ct, held);
      end
      if (out_valid && out_ready && exp_q.size() > 0 && acc_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 60 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] exp, output int acc);
    exp_q.push_back(exp);
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    wait_accept(acc);
    in_valid = 1'b0;
    in_pt    = ~pt;
    in_key   = ~key;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a1, a2, n;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_flags", 128'({out_valid, busy, round}), 128'd0);
    chk("rst_ct", out_ct, 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // FIPS-197 App. B, with round key 1 and RUN flags.
    send(PT_B, KEY_B, CT_B, a1);
    chk("run_flags", 128'({in_ready, busy, round}), 128'({1'b0, 1'b1, 4'd1}));
    @(posedge clk);
    #1;
    chk("k1", dut.r_key, K1_B);
    chk("round2", 128'(round), 128'd2);
    wait_drain();

    // FIPS-197 App. C.1.
    send(PT_C, KEY_C, CT_C, a1);
    wait_drain();

    // All-zero block under 20 cycles of backpressure.
    out_ready = 1'b0;
    send(128'd0, 128'd0, CT_Z, a1);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", 128'(out_valid), 128'd1);
    in_pt  = PT_C;
    in_key = KEY_C;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 in_valid = (i % 3 == 0);
      @(negedge clk);
      chk("bp_hold", 128'({out_valid, in_ready}), 128'({1'b1, 1'b0}));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    wait_drain();

    // Back-to-back with in_valid and out_ready held; inputs change mid-RUN.
    exp_q.push_back(CT_B);
    exp_q.push_back(CT_C);
    in_pt    = PT_B;
    in_key   = KEY_B;
    in_valid = 1'b1;
    wait_accept(a1);
    in_pt  = PT_C;
    in_key = KEY_C;
    wait_accept(a2);
    in_valid = 1'b0;
    chk("b2b_gap", 128'(a2 - a1), 128'd12);
    wait_drain();

    // Asynchronous reset at round 5, then a clean block.
    send(PT_C, KEY_C, CT_C, a1);
    n = 0;
    while (round != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_round5", 128'(round), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", 128'({out_valid, busy, round}), 128'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("no_stale", 128'(out_valid), 128'd0);
    end
    send(PT_C, KEY_C, CT_C, a1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_iter_ctrl.md
Name: aes128_iter_ctrl

Overview:
- Iterative AES-128 encryption engine controller.
- Accepts one plaintext/key pair over a valid/ready handshake and holds the 128-bit state in a register.
- Sequences the round datapath (`operations`) for rounds 1-9, then a final round of SubBytes, ShiftRows and AddRoundKey with no MixColumns, expanding round keys on the fly.
- Returns the ciphertext over a valid/ready handshake; it is the top-level sequencer of the encryptor.

Parameters:
- NUM_ROUNDS, 10, total rounds; only 10 (AES-128) is supported, and other values are an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext/key offered.
- in_ready  output  1  block can accept; high only in IDLE.
- in_pt  input  128  plaintext; bits[127:120] = byte0; state[r][c] = byte 4c+r.
- in_key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_ct  output  128  ciphertext, same byte order.
- busy  output  1  high in RUN.
- round  output  4  current round index, 0 when idle.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (async, rst_n=0) forces the following regardless of clock:
  - FSM=IDLE; state reg, key reg and out_ct = 0; round counter = 0.
  - in_ready=1 after release, out_valid=0, busy=0.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge E0: state <= in_pt ^ in_key (round 0 AddRoundKey), key reg <= in_key, round <= 1, go to RUN.
  - Inputs are sampled only at E0; later changes are ignored.
- RUN: in_ready=0, busy=1. At each edge:
  - Compute round key K[round] from key reg: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[round]; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'. Rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10 (MSB byte of word).
  - round 1..9: state <= operations(state, K[round]); key reg <= K[round]; round++.
  - round 10: state <= ARK(SR(SB(state)), K[10]); go to DONE.
  - Exactly one round per cycle, no stalls. Edges E1..E10 apply rounds 1..10.
- DONE:
  - out_valid=1 and out_ct=state, both from registers starting the cycle after E10 (10 clocks after the accepting edge); busy=0, in_ready=0.
  - out_ct holds stable while out_valid & !out_ready (backpressure of any length).
  - On out_valid & out_ready: go to IDLE, out_valid<=0, round<=0.
- Throughput: with out_ready tied 1, a new block is accepted at most every 12 cycles.
- in_valid during RUN/DONE is ignored (not accepted, not queued); the upstream holds it until in_ready.
- Keys used in one block never leak into the next; the key reg reloads on every accept.
- round output: 0 in IDLE; 1..10 in RUN (the value being applied); 10 in DONE.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse is produced.
- S-box and key schedule are combinational from registers; no combinational path from in_* to out_*.

Test Plan:
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> out_ct 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept. Internal K[1] = a0fafe1788542cb123a339392a6c7605.
- FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero pt and key -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_ct stable and out_valid high throughout; in_valid pulses meanwhile are not accepted (in_ready=0). Release -> IDLE next cycle.
- Back-to-back: App. B then App. C.1 with in_valid and out_ready held 1 -> both results correct, in order, accepts 12 cycles apart; inputs changed mid-RUN do not corrupt result 1.
- Reset at round 5: drive rst_n=0 asynchronously -> out_valid=0, busy=0, round=0 immediately. After release, a new App. C.1 block completes correctly and no stale output appears.
